// File: rtl/spi_burst_sequencer.sv
// SPI master transaction controller: SCLK generation, CS setup/hold framing,
// bit/word counting and TX/RX word handoff for bursts of back-to-back words.
module spi_burst_sequencer #(
  parameter int WordLen = 8,
  parameter int DivLen  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [7:0]         NumWords,
  input  logic [DivLen-1:0]  ClkDiv,
  input  logic               CPOL,
  input  logic               CPHA,
  input  logic [WordLen-1:0] TxData,
  output logic               TxLoad,
  output logic [WordLen-1:0] RxData,
  output logic               RxValid,
  input  logic               MISO,
  output logic               MOSI,
  output logic               SCLK,
  output logic               CSn,
  output logic               Busy,
  output logic               Done
);

  localparam int BitW = $clog2(WordLen) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t               state, stateN;
  logic [DivLen-1:0]    timer, timerN, divLat, divN;
  logic                 cpolLat, cpolN, cphaLat, cphaN;
  logic [7:0]           numLat, numN;
  logic [8:0]           wordCnt, wordN, wordsAfter;
  logic [BitW-1:0]      bitCnt, bitN, bitsAfter;
  logic [WordLen-1:0]   txSr, txSrN, rxSr, rxSrN, rxDataN;
  logic                 rxValidN, sclkN, csnN, busyN, doneN;
  logic                 expire, leading, sample, lastSample;

  assign MOSI = txSr[WordLen-1];

  always_comb begin
    stateN     = state;
    timerN     = timer;
    divN       = divLat;
    cpolN      = cpolLat;
    cphaN      = cphaLat;
    numN       = numLat;
    wordN      = wordCnt;
    bitN       = bitCnt;
    txSrN      = txSr;
    rxSrN      = rxSr;
    rxDataN    = RxData;
    rxValidN   = 1'b0;
    sclkN      = SCLK;
    TxLoad     = 1'b0;
    expire     = (timer == '0);
    // A leading edge is one that leaves the idle level.
    leading    = (SCLK == cpolLat);
    sample     = leading ^ cphaLat;
    lastSample = sample && (bitCnt == BitW'(WordLen - 1));
    bitsAfter  = bitCnt + BitW'(sample);
    wordsAfter = wordCnt + 9'(lastSample);

    case (state)
      IDLE: begin
        sclkN = CPOL;
        if (Start && NumWords != 8'd0) begin
          numN   = NumWords;
          divN   = ClkDiv;
          cpolN  = CPOL;
          cphaN  = CPHA;
          timerN = ClkDiv;
          wordN  = '0;
          bitN   = '0;
          TxLoad = 1'b1;
          txSrN  = TxData;
          stateN = SETUP;
        end
      end
      SETUP: begin
        if (expire) begin
          stateN = XFER;
          timerN = divLat;
        end else begin
          timerN = timer - DivLen'(1);
        end
      end
      XFER: begin
        if (!expire) begin
          timerN = timer - DivLen'(1);
        end else begin
          timerN = divLat;
          sclkN  = ~SCLK;
          if (sample) begin
            rxSrN = {rxSr[WordLen-2:0], MISO};
            bitN  = bitCnt + BitW'(1);
            if (lastSample) begin
              rxDataN  = {rxSr[WordLen-2:0], MISO};
              rxValidN = 1'b1;
              wordN    = wordCnt + 9'd1;
            end
          end else if (!(leading && bitCnt == '0)) begin
            // CPHA=1 skips the first leading edge: bit 0 is already on MOSI.
            txSrN = {txSr[WordLen-2:0], 1'b0};
          end
          // Word boundary: trailing edge once all bits of the word are sampled.
          if (!leading && bitsAfter == BitW'(WordLen)) begin
            bitN = '0;
            if (wordsAfter < {1'b0, numLat}) begin
              TxLoad = 1'b1;
              txSrN  = TxData;
            end else begin
              stateN = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (expire) begin
          stateN = IDLE;
          txSrN  = '0;
        end else begin
          timerN = timer - DivLen'(1);
        end
      end
      default: stateN = IDLE;
    endcase

    csnN  = (stateN == IDLE);
    busyN = (stateN != IDLE);
    doneN = (stateN == HOLD) && (timerN == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      divLat  <= '0;
      cpolLat <= 1'b0;
      cphaLat <= 1'b0;
      numLat  <= '0;
      wordCnt <= '0;
      bitCnt  <= '0;
      txSr    <= '0;
      rxSr    <= '0;
      RxData  <= '0;
      RxValid <= 1'b0;
      SCLK    <= 1'b0;
      CSn     <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= stateN;
      timer   <= timerN;
      divLat  <= divN;
      cpolLat <= cpolN;
      cphaLat <= cphaN;
      numLat  <= numN;
      wordCnt <= wordN;
      bitCnt  <= bitN;
      txSr    <= txSrN;
      rxSr    <= rxSrN;
      RxData  <= rxDataN;
      RxValid <= rxValidN;
      SCLK    <= sclkN;
      CSn     <= csnN;
      Busy    <= busyN;
      Done    <= doneN;
    end
  end

endmodule
